// File: rtl/priority_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter_pkg
// Description : Shared types, constants and helpers for the 4-way arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package priority_arbiter_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    function automatic logic [NREQ-1:0] onehot(input logic [1:0] id);
        logic [NREQ-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/priority_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter_if
// Description : Request/grant bundle between requesters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface priority_arbiter_if;
    import priority_arbiter_pkg::*;

    logic            enable;
    logic            mode;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] grant;
    logic [1:0]      grant_id;
    logic            grant_valid;
    logic            timeout;

    modport master (
        output enable, mode, req,
        input  grant, grant_id, grant_valid, timeout
    );

    modport slave (
        input  enable, mode, req,
        output grant, grant_id, grant_valid, timeout
    );
endinterface
`default_nettype wire

// File: rtl/priority_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module      : arb_pick
// Description : Combinational winner selection, fixed priority or round-robin.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_pick
    import priority_arbiter_pkg::*;
(
    input  wire logic [NREQ-1:0] req,
    input  wire logic            mode,
    input  wire logic [1:0]      last_id,
    output logic      [1:0]      win_id,
    output logic                 win_valid
);

    logic [1:0] w_idx;

    // Both loops run lowest-precedence first so the final hit is the winner.
    always_comb begin
        win_id    = 2'd0;
        win_valid = |req;
        w_idx     = 2'd0;
        if (!mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (req[i]) win_id = 2'(i);
            end
        end else begin
            for (int k = NREQ; k >= 1; k--) begin
                w_idx = last_id + 2'(k);
                if (req[w_idx]) win_id = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : priority_arbiter
// Description : 4-requester arbiter with hold limit and one-cycle turnaround.
// Revision    : 1.0 - initial release
// ============================================================================
module priority_arbiter
    import priority_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  wire logic         clk,
    input  wire logic         rst,
    priority_arbiter_if.slave arb
);

    localparam logic [CNT_W-1:0] c_max_hold = CNT_W'(MAX_HOLD);

    arb_state_t        r_state, w_state_n;
    logic [NREQ-1:0]   r_grant, w_grant_n;
    logic [1:0]        r_grant_id, w_grant_id_n;
    logic              r_valid, w_valid_n;
    logic              r_timeout, w_timeout_n;
    logic [CNT_W-1:0]  r_hold, w_hold_n;
    logic [1:0]        r_last, w_last_n;
    logic [1:0]        w_win_id;
    logic              w_win_valid;

    arb_pick u_pick (
        .req       (arb.req),
        .mode      (arb.mode),
        .last_id   (r_last),
        .win_id    (w_win_id),
        .win_valid (w_win_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_grant    <= '0;
            r_grant_id <= 2'd0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold     <= '0;
            r_last     <= 2'd3;
        end else begin
            r_state    <= w_state_n;
            r_grant    <= w_grant_n;
            r_grant_id <= w_grant_id_n;
            r_valid    <= w_valid_n;
            r_timeout  <= w_timeout_n;
            r_hold     <= w_hold_n;
            r_last     <= w_last_n;
        end
    end

    always_comb begin
        w_state_n    = r_state;
        w_grant_n    = r_grant;
        w_grant_id_n = r_grant_id;
        w_valid_n    = r_valid;
        w_timeout_n  = 1'b0;
        w_hold_n     = r_hold;
        w_last_n     = r_last;
        case (r_state)
            ST_IDLE: begin
                w_grant_n = '0;
                w_valid_n = 1'b0;
                if (arb.enable && w_win_valid) begin
                    w_state_n    = ST_GRANT;
                    w_grant_n    = onehot(w_win_id);
                    w_grant_id_n = w_win_id;
                    w_valid_n    = 1'b1;
                    w_hold_n     = CNT_W'(1);
                    w_last_n     = w_win_id;
                end
            end
            ST_GRANT: begin
                // Owner release is checked before the hold limit.
                if (!arb.req[r_grant_id]) begin
                    w_state_n = ST_GAP;
                    w_grant_n = '0;
                    w_valid_n = 1'b0;
                end else if (r_hold == c_max_hold) begin
                    w_state_n   = ST_GAP;
                    w_grant_n   = '0;
                    w_valid_n   = 1'b0;
                    w_timeout_n = 1'b1;
                end else begin
                    w_hold_n = r_hold + CNT_W'(1);
                end
            end
            ST_GAP: begin
                w_state_n = ST_IDLE;
                w_grant_n = '0;
                w_valid_n = 1'b0;
            end
            default: begin
                w_state_n = ST_IDLE;
                w_grant_n = '0;
                w_valid_n = 1'b0;
            end
        endcase
    end

    assign arb.grant       = r_grant;
    assign arb.grant_id    = r_grant_id;
    assign arb.grant_valid = r_valid;
    assign arb.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_priority_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_priority_arbiter
// Description : Directed plus random bench against a cycle-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_priority_arbiter;
    import priority_arbiter_pkg::*;

    localparam int MAX_HOLD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    priority_arbiter_if bus ();

    priority_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .arb (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: owner index (-1 when none), a pending-gap flag,
    // cycles held so far, last winner and the registered id/timeout.
    int m_owner = -1;
    bit m_gap   = 0;
    int m_held  = 0;
    int m_last  = 3;
    int m_id    = 0;
    bit m_to    = 0;

    int order_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic int pick(input logic [3:0] r, input bit md, input int last);
        if (!md) begin
            for (int i = 3; i >= 0; i--) if (r[i]) return i;
        end else begin
            for (int k = 1; k <= 4; k++) if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_edge(input bit r_st, input bit en, input bit md, input logic [3:0] r);
        if (r_st) begin
            m_owner = -1; m_gap = 0; m_held = 0; m_last = 3; m_id = 0; m_to = 0;
        end else if (m_owner >= 0) begin
            m_to = 0;
            if (!r[m_owner]) begin
                m_owner = -1; m_gap = 1;
            end else if (m_held == MAX_HOLD) begin
                m_owner = -1; m_gap = 1; m_to = 1;
            end else begin
                m_held++;
            end
        end else if (m_gap) begin
            m_gap = 0; m_to = 0;
        end else begin
            m_to = 0;
            if (en && r != 4'd0) begin
                m_owner = pick(r, md, m_last);
                m_id    = m_owner;
                m_last  = m_owner;
                m_held  = 1;
                order_q.push_back(m_owner);
            end
        end
    endtask

    task automatic step(input bit r_st, input bit en, input bit md, input logic [3:0] r);
        logic [3:0] exp_g;
        @(negedge clk);
        rst = r_st; bus.enable = en; bus.mode = md; bus.req = r;
        @(posedge clk);
        model_edge(r_st, en, md, r);
        #1;
        exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'd0;
        check("grant",       32'(bus.grant),       32'(exp_g));
        check("grant_id",    32'(bus.grant_id),    32'(m_id));
        check("grant_valid", 32'(bus.grant_valid), 32'(m_owner >= 0));
        check("timeout",     32'(bus.timeout),     32'(m_to));
    endtask

    logic [3:0] r;
    int exp_order[5] = '{0, 1, 2, 3, 0};
    int to_cnt;
    bit md_r;

    initial begin
        bus.enable = 1'b0; bus.mode = 1'b0; bus.req = 4'd0;

        // Reset, then idle with no requests
        step(1, 0, 0, 4'd0);
        step(1, 0, 0, 4'd0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 4'd0);

        // Fixed priority: 0110 -> id 2, drop req[2] -> gap -> id 1
        for (int i = 0; i < 3; i++) step(0, 1, 0, 4'b0110);
        check("fixed_first_id", 32'(bus.grant_id), 32'd2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 4'b0010);
        check("fixed_second_grant", 32'(bus.grant), 32'b0010);
        step(0, 1, 0, 4'd0);
        step(0, 1, 0, 4'd0);

        // Round-robin from reset, owners drop after 3 cycles
        step(1, 1, 1, 4'd0);
        order_q.delete();
        for (int i = 0; i < 26; i++) begin
            r = 4'hF;
            if (m_owner >= 0 && m_held >= 3) r[m_owner] = 1'b0;
            step(0, 1, 1, r);
        end
        check("rr_count", 32'(order_q.size() >= 5), 32'd1);
        for (int i = 0; i < 5; i++)
            if (i < order_q.size()) check("rr_order", 32'(order_q[i]), 32'(exp_order[i]));

        // Hold limit with a single persistent requester
        step(1, 1, 0, 4'd0);
        to_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            step(0, 1, 0, 4'b0001);
            if (bus.timeout) to_cnt++;
        end
        check("timeout_pulses", 32'(to_cnt), 32'd2);

        // enable=0 keeps the live grant but blocks new arbitration
        step(1, 1, 0, 4'd0);
        step(0, 1, 0, 4'b0010);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 4'b0010);
        check("en_low_kept", 32'(bus.grant), 32'b0010);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 4'b0100);
        check("en_low_blocked", 32'(bus.grant_valid), 32'd0);
        step(0, 1, 0, 4'b0100);
        check("en_high_grant", 32'(bus.grant), 32'b0100);

        // Reset mid-grant, then RR from 0 still finds id 3
        step(0, 1, 0, 4'd0);
        step(0, 1, 0, 4'd0);
        step(0, 1, 0, 4'b1000);
        step(0, 1, 0, 4'b1000);
        step(1, 1, 0, 4'b1000);
        check("rst_mid_grant", 32'(bus.grant), 32'd0);
        step(0, 1, 1, 4'b1000);
        check("rr_after_rst", 32'(bus.grant_id), 32'd3);

        // Random traffic
        md_r = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(19) == 0) md_r = ~md_r;
            r = 4'($urandom_range(15));
            if (m_owner >= 0 && $urandom_range(3) != 0) r[m_owner] = 1'b1;
            step($urandom_range(99) == 0, $urandom_range(7) != 0, md_r, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
